// File: rtl/frame_wr_buf.sv
// Video-to-DDR line write buffer: packs pixels into DDR words, queues
// them per line and issues one write command per line into a ping-pong frame.
module frame_wr_buf #(
  parameter int          ADDR_WIDTH      = 28,
  parameter int unsigned ADDR_OFFSET     = 0,
  parameter int          H_NUM           = 640,
  parameter int          V_NUM           = 720,
  parameter int          H_ORIGNAL       = 1280,
  parameter int          DQ_WIDTH        = 32,
  parameter int          LEN_WIDTH       = 32,
  parameter int          PIX_WIDTH       = 16,
  parameter int          LINE_ADDR_WIDTH = 22,
  parameter int          FRAME_CNT_WIDTH = ADDR_WIDTH - LINE_ADDR_WIDTH
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rstn,
  input  logic                       wr_fsync,
  input  logic                       wr_en,
  input  logic [PIX_WIDTH-1:0]       wr_data,
  input  logic                       begin_next,
  output logic                       ddr_wreq,
  output logic [ADDR_WIDTH-1:0]      ddr_waddr,
  output logic [LEN_WIDTH-1:0]       ddr_wr_len,
  input  logic                       ddr_wrdy,
  input  logic                       ddr_wdone,
  output logic [8*DQ_WIDTH-1:0]      ddr_wdata,
  input  logic                       ddr_wdata_req,
  output logic [FRAME_CNT_WIDTH-1:0] frame_wcnt,
  output logic                       frame_wirq,
  output logic                       done_next,
  output logic                       state,
  output logic                       ovf
);

  localparam int DW    = 8 * DQ_WIDTH;
  localparam int PPW   = DW / PIX_WIDTH;
  localparam int WPL   = H_NUM / PPW;
  localparam int PITCH = H_ORIGNAL * PIX_WIDTH / DQ_WIDTH;
  localparam int DEPTH = 2 * WPL;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PCW   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int HCW   = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam int VCW   = $clog2(V_NUM + 1);

  localparam logic [PCW-1:0] P_LAST = PCW'(PPW - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(H_NUM - 1);
  localparam logic [VCW-1:0] V_MAX  = VCW'(V_NUM);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_NUM - 1);
  localparam logic [AW-1:0]  A_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  C_LINE = CW'(WPL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE
  } fsm_t;

  fsm_t fsm;
  logic fsync_q;

  logic [DW-1:0]  word_q;
  logic [DW-1:0]  word_nxt;
  logic [PCW-1:0] pcnt;
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vin;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic                  busy;
  logic [VCW-1:0]        vcmd;
  logic [ADDR_WIDTH-1:0] line_addr;

  logic fsync_rise;
  logic capture;
  logic start;
  logic pix_ok;
  logic push;
  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic issue;
  logic wdone_ok;
  logic frame_done;

  assign fsync_rise = wr_fsync & ~fsync_q;
  assign capture    = (fsm == S_CAPTURE);
  assign start      = (fsm == S_ARMED) & fsync_rise;
  assign pix_ok     = capture & wr_en & (vin < V_MAX);
  assign push       = pix_ok & (pcnt == P_LAST);
  assign full       = (cnt == C_FULL);
  assign empty      = (cnt == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = ddr_wdata_req & ~empty;
  assign issue      = capture & ~busy & (cnt >= C_LINE) & (vcmd < V_MAX);
  assign wdone_ok   = capture & busy & ddr_wdone;
  assign frame_done = wdone_ok & (vcmd == V_LAST);

  // New pixel enters at the top so the first pixel ends up in the low bits.
  assign word_nxt = (word_q >> PIX_WIDTH)
                  | (DW'(wr_data) << (DW - PIX_WIDTH));

  assign ddr_wdata = mem[rptr];

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      fsm        <= S_IDLE;
      state      <= 1'b0;
      fsync_q    <= 1'b0;
      frame_wirq <= 1'b0;
      done_next  <= 1'b0;
      frame_wcnt <= '0;
    end else begin
      fsync_q    <= wr_fsync;
      frame_wirq <= 1'b0;
      done_next  <= 1'b0;
      unique case (fsm)
        S_IDLE: begin
          if (begin_next) begin
            fsm   <= S_ARMED;
            state <= 1'b1;
          end
        end
        S_ARMED: begin
          if (fsync_rise) fsm <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (frame_done) begin
            fsm        <= S_IDLE;
            state      <= 1'b0;
            frame_wirq <= 1'b1;
            done_next  <= 1'b1;
            frame_wcnt <= frame_wcnt + FRAME_CNT_WIDTH'(1);
          end
        end
        default: begin
          fsm   <= S_IDLE;
          state <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      word_q <= '0;
      pcnt   <= '0;
      hcnt   <= '0;
      vin    <= '0;
    end else if (start) begin
      word_q <= '0;
      pcnt   <= '0;
      hcnt   <= '0;
      vin    <= '0;
    end else if (pix_ok) begin
      word_q <= word_nxt;
      pcnt   <= (pcnt == P_LAST) ? '0 : pcnt + PCW'(1);
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vin  <= vin + VCW'(1);
      end else begin
        hcnt <= hcnt + HCW'(1);
      end
    end
  end

  // A full FIFO drops the incoming word; the loss is latched in ovf.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push & full) ovf <= 1'b1;
      if (start) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push_ok) begin
          mem[wptr] <= word_nxt;
          wptr      <= (wptr == A_LAST) ? '0 : wptr + AW'(1);
        end
        if (pop_ok) begin
          rptr <= (rptr == A_LAST) ? '0 : rptr + AW'(1);
        end
        unique case ({push_ok, pop_ok})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      ddr_wreq   <= 1'b0;
      ddr_waddr  <= '0;
      ddr_wr_len <= '0;
      busy       <= 1'b0;
      vcmd       <= '0;
      line_addr  <= '0;
    end else if (start) begin
      ddr_wreq  <= 1'b0;
      busy      <= 1'b0;
      vcmd      <= '0;
      line_addr <= '0;
    end else begin
      if (ddr_wreq & ddr_wrdy) ddr_wreq <= 1'b0;
      if (issue) begin
        ddr_wreq   <= 1'b1;
        busy       <= 1'b1;
        ddr_wr_len <= LEN_WIDTH'(WPL);
        ddr_waddr  <= ADDR_WIDTH'(ADDR_OFFSET)
                    + (ADDR_WIDTH'(frame_wcnt[0]) << LINE_ADDR_WIDTH)
                    + line_addr;
      end
      if (wdone_ok) begin
        busy      <= 1'b0;
        vcmd      <= vcmd + VCW'(1);
        line_addr <= line_addr + ADDR_WIDTH'(PITCH);
      end
    end
  end

endmodule

// File: tb/tb_frame_wr_buf.sv
// Scoreboard bench for frame_wr_buf: stimulus queues expected commands and
// words, a responder/monitor pops and compares as the DUT presents them.
module tb_frame_wr_buf;

  localparam int AWD  = 28;
  localparam int HN   = 64;
  localparam int VN   = 6;
  localparam int HO   = 128;
  localparam int DQW  = 32;
  localparam int LW   = 32;
  localparam int PW   = 16;
  localparam int LAW  = 22;
  localparam int FCW  = AWD - LAW;
  localparam int DW   = 8 * DQW;
  localparam int PPW  = 16;
  localparam int WPL  = 4;
  localparam int PTCH = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_fsync;
  logic           wr_en;
  logic [PW-1:0]  wr_data;
  logic           begin_next;
  logic           ddr_wreq;
  logic [AWD-1:0] ddr_waddr;
  logic [LW-1:0]  ddr_wr_len;
  logic           ddr_wrdy;
  logic           ddr_wdone;
  logic [DW-1:0]  ddr_wdata;
  logic           ddr_wdata_req;
  logic [FCW-1:0] frame_wcnt;
  logic           frame_wirq;
  logic           done_next;
  logic           state;
  logic           ovf;

  frame_wr_buf #(
    .ADDR_WIDTH(AWD), .ADDR_OFFSET(0), .H_NUM(HN), .V_NUM(VN),
    .H_ORIGNAL(HO), .DQ_WIDTH(DQW), .LEN_WIDTH(LW), .PIX_WIDTH(PW),
    .LINE_ADDR_WIDTH(LAW), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .ddr_clk(clk), .ddr_rstn(rst_n), .wr_fsync(wr_fsync),
    .wr_en(wr_en), .wr_data(wr_data), .begin_next(begin_next),
    .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr),
    .ddr_wr_len(ddr_wr_len), .ddr_wrdy(ddr_wrdy),
    .ddr_wdone(ddr_wdone), .ddr_wdata(ddr_wdata),
    .ddr_wdata_req(ddr_wdata_req), .frame_wcnt(frame_wcnt),
    .frame_wirq(frame_wirq), .done_next(done_next),
    .state(state), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int irq_cnt = 0;
  bit resp_en = 1'b0;

  logic [DW-1:0]  exp_data_q[$];
  logic [AWD-1:0] exp_addr_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wreq"}, ddr_wreq, 0);
    chk({tag, "_waddr"}, ddr_waddr, 0);
    chk({tag, "_len"}, ddr_wr_len, 0);
    chk({tag, "_wdata"}, ddr_wdata, 0);
    chk({tag, "_wcnt"}, frame_wcnt, 0);
    chk({tag, "_wirq"}, frame_wirq, 0);
    chk({tag, "_done"}, done_next, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic drive_pix(input int base, input int line, input int n,
                           input bit push_exp);
    logic [DW-1:0] w;
    logic [PW-1:0] p;
    w = '0;
    for (int i = 0; i < n; i++) begin
      p = PW'(base + line * HN + i);
      wr_en = 1'b1;
      wr_data = p;
      w[PW*(i%PPW) +: PW] = p;
      if ((i % PPW == PPW - 1) && push_exp) exp_data_q.push_back(w);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic arm();
    begin_next = 1'b1;
    step();
    begin_next = 1'b0;
    step();
    wr_fsync = 1'b1;
    step();
    wr_fsync = 1'b0;
  endtask

  task automatic run_frame(input int base, input bit sel,
                           input int exp_wcnt);
    int prev;
    prev = irq_cnt;
    for (int n = 0; n < VN; n++)
      exp_addr_q.push_back(AWD'((int'(sel) << LAW) + n * PTCH));
    arm();
    chk("state_busy", state, 1);
    for (int l = 0; l < VN; l++) drive_pix(base, l, HN, 1'b1);
    for (int c = 0; c < 3000 && irq_cnt == prev; c++) step();
    chk("frame_irq", irq_cnt, prev + 1);
    step();
    chk("frame_wcnt", frame_wcnt, exp_wcnt);
    chk("state_idle", state, 0);
    chk("cmds_left", exp_addr_q.size(), 0);
    chk("words_left", exp_data_q.size(), 0);
  endtask

  // Command responder: accepts each request, pops a line, signals done.
  initial begin
    logic [AWD-1:0] ea;
    logic [DW-1:0]  ed;
    ddr_wrdy = 1'b0;
    ddr_wdone = 1'b0;
    ddr_wdata_req = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && ddr_wreq) begin
        if (exp_addr_q.size() == 0) begin
          chk("cmd_unexpected", 1, 0);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("waddr", ddr_waddr, ea);
        end
        chk("wr_len", ddr_wr_len, WPL);
        ddr_wrdy = 1'b1;
        @(negedge clk);
        ddr_wrdy = 1'b0;
        chk("wreq_drop", ddr_wreq, 0);
        for (int k = 0; k < WPL; k++) begin
          ddr_wdata_req = 1'b1;
          if (exp_data_q.size() == 0) begin
            chk("word_unexpected", 1, 0);
          end else begin
            ed = exp_data_q.pop_front();
            chk("wdata", ddr_wdata, ed);
          end
          @(negedge clk);
        end
        ddr_wdata_req = 1'b0;
        ddr_wdone = 1'b1;
        @(negedge clk);
        ddr_wdone = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_wirq) begin
      irq_cnt++;
      chk("done_with_irq", done_next, 1);
    end else if (done_next) begin
      chk("done_without_irq", done_next, 0);
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_fsync = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    begin_next = 1'b0;
    #12;
    chk_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    // Not armed: pixels and fsync must be ignored.
    drive_pix(0, 0, 40, 1'b0);
    wr_fsync = 1'b1;
    step();
    wr_fsync = 1'b0;
    drive_pix(0, 0, 40, 1'b0);
    for (int c = 0; c < 10; c++) step();
    chk("idle_wreq", ddr_wreq, 0);
    chk("idle_state", state, 0);

    resp_en = 1'b1;
    run_frame(0, 1'b0, 1);
    run_frame(1000, 1'b1, 2);

    // Stalled controller: request must hold, third line overflows.
    resp_en = 1'b0;
    arm();
    drive_pix(3000, 0, HN, 1'b0);
    for (int c = 0; c < 20 && !ddr_wreq; c++) step();
    chk("hold_wreq0", ddr_wreq, 1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("hold_wreq", ddr_wreq, 1);
      chk("hold_waddr", ddr_waddr, 0);
      chk("hold_len", ddr_wr_len, WPL);
    end
    step();
    drive_pix(3000, 1, HN, 1'b0);
    step();
    chk("ovf_before", ovf, 0);
    drive_pix(3000, 2, HN, 1'b0);
    step();
    chk("ovf_after", ovf, 1);

    // Asynchronous reset in the middle of a line.
    drive_pix(3000, 3, 20, 1'b0);
    wr_en = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_addr_q.delete();
    exp_data_q.delete();
    chk_zero("midrst");
    wr_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    resp_en = 1'b1;
    run_frame(5000, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_wr_buf.md
Name: frame_wr_buf

Overview:
- Single-clock video-to-DDR write buffer.
- Packs incoming pixels into 8*DQ_WIDTH-bit words and holds them in an internal line FIFO.
- Issues one DDR write command per completed line into a ping-pong frame area.
- Sits between the video capture path and the DDR write/read controller; captures one frame per begin_next arm.

Parameters:
- ADDR_WIDTH, 28: DDR command address width.
- ADDR_OFFSET, 0: base address of the frame area.
- H_NUM, 640: pixels per line written.
- V_NUM, 720: lines per frame.
- H_ORIGNAL, 1280: line pitch in pixels; must be >= H_NUM.
- DQ_WIDTH, 32: DDR DQ width; data word is 8*DQ_WIDTH bits.
- LEN_WIDTH, 32: command length width.
- PIX_WIDTH, 16: pixel width; must divide 8*DQ_WIDTH.
- LINE_ADDR_WIDTH, 22: address bits spanning one frame buffer.
- FRAME_CNT_WIDTH, ADDR_WIDTH-LINE_ADDR_WIDTH: frame counter width.

Ports:
- ddr_clk  in  1  sole clock.
- ddr_rstn  in  1  asynchronous active-low reset.
- wr_fsync  in  1  frame sync; rising edge starts a frame.
- wr_en  in  1  pixel valid.
- wr_data  in  PIX_WIDTH  pixel.
- begin_next  in  1  one-cycle pulse; arms capture of the next frame.
- ddr_wreq  out  1  write command request.
- ddr_waddr  out  ADDR_WIDTH  command address.
- ddr_wr_len  out  LEN_WIDTH  command length in data words.
- ddr_wrdy  in  1  command accepted when high with ddr_wreq.
- ddr_wdone  in  1  pulse: command's data fully written.
- ddr_wdata  out  8*DQ_WIDTH  FIFO head word (first-word fall-through).
- ddr_wdata_req  in  1  pops one word per high cycle.
- frame_wcnt  out  FRAME_CNT_WIDTH  completed-frame counter.
- frame_wirq  out  1  one-cycle pulse at frame completion.
- done_next  out  1  one-cycle pulse, same cycle as frame_wirq.
- state  out  1  high while ARMED or CAPTURE.
- ovf  out  1  sticky FIFO overflow flag.

Behaviour:
- Derived constants:
  - PPW = 8*DQ_WIDTH/PIX_WIDTH (16 by default).
  - WPL = H_NUM/PPW words per line (40 by default).
  - PITCH = H_ORIGNAL*PIX_WIDTH/DQ_WIDTH address units per line (640 by default).
- Reset values: all outputs 0, FSM IDLE, FIFO empty, counters 0.
- FSM states:
  - IDLE -> ARMED on begin_next.
  - ARMED -> CAPTURE on wr_fsync rising edge (edge detected against the previous-cycle value).
  - CAPTURE -> IDLE in the cycle after the ddr_wdone of line V_NUM-1; frame_wirq and done_next pulse in that cycle and frame_wcnt increments (wraps).
  - begin_next outside IDLE is ignored. wr_fsync outside ARMED is ignored.
- Packing (CAPTURE only):
  - Each wr_en pixel is shifted into the word register, first pixel of a word in bits [PIX_WIDTH-1:0].
  - Every PPW pixels the word is pushed into the FIFO.
  - The pixel counter wraps at H_NUM.
  - Pixels beyond V_NUM lines are ignored. wr_en outside CAPTURE is ignored.
- FIFO:
  - Depth 2*WPL words.
  - Push when full: the word is dropped and ovf is set; ovf clears only on reset.
  - Simultaneous push and pop are both honoured.
- Command issue:
  - One outstanding command at a time.
  - When at least WPL words are buffered for line n and no command is pending, raise ddr_wreq with ddr_waddr = ADDR_OFFSET + (frame_wcnt[0] << LINE_ADDR_WIDTH) + n*PITCH and ddr_wr_len = WPL.
  - ddr_wreq, ddr_waddr and ddr_wr_len stay stable until the cycle ddr_wrdy is high; ddr_wreq drops the next cycle.
  - The next command is not issued before ddr_wdone.
  - The controller pops exactly WPL words per command; popping an empty FIFO returns the stale head and has no effect.
- Ping-pong: buffer select is frame_wcnt[0], so consecutive frames alternate between two regions.
- Async reset mid-frame: everything returns to reset values immediately; no further requests.

Test Plan:
- Reset, then wr_en bursts with no begin_next -> ddr_wreq stays 0 and state=0.
- begin_next, fsync, 640 pixels with values 0..639 -> ddr_wreq with addr=0 and len=40; after ddr_wrdy, pops return word0 = {pix15..pix0}.
- Full 720-line frame with ddr_wrdy/ddr_wdone responder -> 720 commands at addresses n*640; frame_wirq and done_next pulse once; frame_wcnt=1; state=0.
- Second armed frame -> first address = 1<<22.
- Hold ddr_wrdy low 50 cycles -> ddr_wreq, ddr_waddr and ddr_wr_len held constant; a third line overflows the FIFO -> ovf=1.
- Assert ddr_rstn low mid-line -> all outputs 0 immediately; a subsequent full arm/frame sequence behaves as the full-frame scenario.
